// File: rtl/ysyx_mem_responder.sv
// Single-outstanding memory responder: valid/ready request in, fixed-latency access
// to an internal word array, held response out until the consumer takes it.
module ysyx_mem_responder #(
    parameter logic [31:0] BASE    = 32'h8000_0000,
    parameter int          DEPTH   = 1024,
    parameter int          LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_wen_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [3:0]  req_wmask_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic [1:0]  dbg_state_o
);
    localparam int          IDX_W    = $clog2(DEPTH);
    localparam logic [32:0] END_ADDR = {1'b0, BASE} + 33'(DEPTH) * 33'd4;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_e;

    // Handshake: a request transfers on an edge where req_valid_i && req_ready_o,
    // a response transfers on an edge where rsp_valid_o && rsp_ready_i.
    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wen_q, wen_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0]      mem_q [DEPTH];
    logic             in_range;
    logic [IDX_W-1:0] idx;
    logic             commit;

    // 33-bit upper bound so a range ending at 4 GiB cannot wrap.
    assign in_range = (addr_q >= BASE) && ({1'b0, addr_q} < END_ADDR);
    assign idx      = IDX_W'((addr_q - BASE) >> 2);
    assign commit   = (state_q == S_BUSY) && (cnt_q == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            wen_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wmask_q <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wen_d   = wen_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    wen_d   = req_wen_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    wmask_d = req_wmask_i;
                    cnt_d   = CNT_INIT;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_d   = !in_range;
                    rdata_d = (in_range && !wen_q) ? mem_q[idx] : 32'd0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready_i) begin
                    rdata_d = 32'd0;
                    err_d   = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready_o = (state_q == S_IDLE);
        rsp_valid_o = (state_q == S_RESP);
        rsp_rdata_o = rdata_q;
        rsp_err_o   = err_q;
        dbg_state_o = state_q;
    end

    // Array is deliberately not reset; a reset before the commit edge drops the write.
    always_ff @(posedge clk) begin
        if (commit && wen_q && in_range) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_q[b]) begin
                    mem_q[idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end
endmodule

// File: tb/tb_ysyx_mem_responder.sv
// Bench for ysyx_mem_responder: directed literal cases followed by random traffic,
// all outputs compared every cycle against a transaction-level reference model.
module tb_ysyx_mem_responder;
    localparam logic [31:0] BASE    = 32'h8000_0000;
    localparam int          DEPTH   = 1024;
    localparam int          LATENCY = 2;

    logic        clk;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_wen_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [3:0]  req_wmask_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic [1:0]  dbg_state_o;

    ysyx_mem_responder #(.BASE(BASE), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_wen_i(req_wen_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
        .rsp_err_o(rsp_err_o), .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // One transaction at a time: accepted at edge n, visible from edge n+LATENCY,
    // retired on the first later edge that sees rsp_ready_i.
    int          cyc = 0;
    bit          m_out = 1'b0;
    int          m_rsp_at = 0;
    logic        m_wen;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_mask;
    logic [31:0] m_mem [int];
    logic [33:0] exp_q [$];  // {data_known, err, rdata}

    task automatic model_commit();
        longint unsigned a, lo, hi;
        int idx;
        logic [31:0] w;
        a  = longint'(m_addr);
        lo = longint'(BASE);
        hi = lo + 4 * DEPTH;
        if (a < lo || a >= hi) begin
            exp_q.push_back({1'b1, 1'b1, 32'h0});
        end else begin
            idx = int'((a - lo) / 4);
            if (m_wen) begin
                if (m_mask == 4'hF) begin
                    m_mem[idx] = m_wdata;
                end else if (m_mem.exists(idx)) begin
                    w = m_mem[idx];
                    for (int b = 0; b < 4; b++)
                        if (m_mask[b]) w[8*b +: 8] = m_wdata[8*b +: 8];
                    m_mem[idx] = w;
                end
                exp_q.push_back({1'b1, 1'b0, 32'h0});
            end else if (m_mem.exists(idx)) begin
                exp_q.push_back({1'b1, 1'b0, m_mem[idx]});
            end else begin
                exp_q.push_back({1'b0, 1'b0, 32'h0});
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_out = 1'b0;
            exp_q.delete();
        end else begin
            cyc++;
            if (m_out) begin
                if (cyc > m_rsp_at && rsp_ready_i) begin
                    m_out = 1'b0;
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                end else if (cyc == m_rsp_at) begin
                    model_commit();
                end
            end else if (req_valid_i) begin
                m_wen    = req_wen_i;
                m_addr   = req_addr_i;
                m_wdata  = req_wdata_i;
                m_mask   = req_wmask_i;
                m_out    = 1'b1;
                m_rsp_at = cyc + LATENCY;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit ev;
        ev = m_out && (cyc >= m_rsp_at);
        chk("req_ready", 32'(req_ready_o), 32'(!m_out));
        chk("rsp_valid", 32'(rsp_valid_o), 32'(ev));
        if (ev && exp_q.size() > 0) begin
            chk("rsp_err", 32'(rsp_err_o), 32'(exp_q[0][32]));
            if (exp_q[0][33]) chk("rsp_rdata", rsp_rdata_o, exp_q[0][31:0]);
        end else begin
            chk("rsp_err_idle", 32'(rsp_err_o), 32'h0);
            chk("rsp_rdata_idle", rsp_rdata_o, 32'h0);
        end
    end

    // ---------------- driver ----------------
    task automatic txn(input logic wen, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] mask, input int hold, input bit noise,
                       output logic [31:0] rd, output logic er, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!req_ready_o && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("req_ready_timeout", 32'(req_ready_o), 32'h1);
        req_valid_i = 1'b1;
        req_wen_i   = wen;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        req_wmask_i = mask;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = noise;
        if (noise) begin
            req_wen_i   = 1'b1;
            req_addr_i  = BASE + 4 * $urandom_range(0, 15);
            req_wdata_i = $urandom;
            req_wmask_i = 4'hF;
        end
        lat = 0;
        while (!rsp_valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) chk("rsp_valid_timeout", 32'(rsp_valid_o), 32'h1);
        rd = rsp_rdata_o;
        er = rsp_err_o;
        repeat (hold) @(negedge clk);
        if (hold > 0) chk("held_req_ready", 32'(req_ready_o), 32'h0);
        rsp_ready_i = 1'b1;
        req_valid_i = 1'b0;
        @(negedge clk);
        rsp_ready_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        rst = 1'b1;
        req_valid_i = 1'b0;
        req_wen_i   = 1'b0;
        req_addr_i  = 32'h0;
        req_wdata_i = 32'h0;
        req_wmask_i = 4'h0;
        rsp_ready_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready_o), 32'h1);
        chk("reset_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("reset_rsp_err", 32'(rsp_err_o), 32'h0);
        chk("reset_dbg_state", 32'(dbg_state_o), 32'h0);
        rst = 1'b0;

        txn(1'b1, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 1'b0, rd, er, lat);
        chk("t2_wr_latency", 32'(lat), 32'd2);
        chk("t2_wr_rdata", rd, 32'h0);
        txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("t2_rd_latency", 32'(lat), 32'd2);
        chk("t2_rd_rdata", rd, 32'hDEAD_BEEF);

        txn(1'b1, 32'h8000_0010, 32'h1122_3344, 4'b0101, 0, 1'b0, rd, er, lat);
        txn(1'b0, 32'h8000_0012, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("t3_partial_rdata", rd, 32'hDE22_BE44);

        txn(1'b1, BASE + 4 * (DEPTH - 1), 32'h0BAD_C0DE, 4'hF, 0, 1'b0, rd, er, lat);
        txn(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("t4_low_err", 32'(er), 32'h1);
        chk("t4_low_rdata", rd, 32'h0);
        txn(1'b0, BASE + 4 * DEPTH, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("t4_high_err", 32'(er), 32'h1);
        txn(1'b1, BASE + 4 * DEPTH, 32'hFFFF_FFFF, 4'hF, 0, 1'b0, rd, er, lat);
        chk("t4_wr_oob_err", 32'(er), 32'h1);
        txn(1'b0, BASE + 4 * (DEPTH - 1), 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("t4_last_word", rd, 32'h0BAD_C0DE);
        chk("t4_last_err", 32'(er), 32'h0);

        txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 5, 1'b1, rd, er, lat);
        chk("t5_held_rdata", rd, 32'hDE22_BE44);

        // Reset while the write to 0x8000_0010 is still waiting for its commit edge.
        @(negedge clk);
        req_valid_i = 1'b1;
        req_wen_i   = 1'b1;
        req_addr_i  = 32'h8000_0010;
        req_wdata_i = 32'hCAFE_F00D;
        req_wmask_i = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_req_ready", 32'(req_ready_o), 32'h1);
        chk("t6_rst_rsp_valid", 32'(rsp_valid_o), 32'h0);
        chk("t6_rst_rsp_err", 32'(rsp_err_o), 32'h0);
        #1 rst = 1'b0;
        txn(1'b0, 32'h8000_0010, 32'h0, 4'h0, 0, 1'b0, rd, er, lat);
        chk("t6_prior_contents", rd, 32'hDE22_BE44);

        for (int w = 0; w < 16; w++)
            txn(1'b1, BASE + 4 * w, $urandom, 4'hF, 0, 1'b0, rd, er, lat);

        for (int n = 0; n < 250; n++) begin
            logic [31:0] a;
            int sel;
            sel = $urandom_range(0, 11);
            case (sel)
                0:       a = BASE - 4 * $urandom_range(1, 4);
                1:       a = BASE + 4 * DEPTH + 4 * $urandom_range(0, 3);
                2:       a = 32'hFFFF_FFFC;
                3:       a = BASE + 4 * (DEPTH - 1);
                default: a = BASE + 4 * $urandom_range(0, 15);
            endcase
            a = a | 32'($urandom_range(0, 3));
            txn(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)),
                $urandom_range(0, 3), 1'($urandom_range(0, 1)), rd, er, lat);
            chk("rand_latency", 32'(lat), 32'(LATENCY));
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end
endmodule
